// File: rtl/pwm_meter_pkg.sv
// rtl/pwm_meter_pkg.sv - shared state encoding and constants for the PWM meter
package pwm_meter_pkg;

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_MEASURE = 1'b1;

  localparam int unsigned DUTY_W      = 8;
  localparam int unsigned SYNC_STAGES = 2;

endpackage

// File: rtl/pwm_meter_div.sv
// rtl/pwm_meter_div.sv - unsigned sequential restoring divider, one quotient bit per clock
module pwm_meter_div #(
  parameter int unsigned num_w_p = 32,
  parameter int unsigned den_w_p = 24
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic               start_in,
  input  logic [num_w_p-1:0] num_in,
  input  logic [den_w_p-1:0] den_in,
  output logic               busy_out,
  output logic               done_out,
  output logic [num_w_p-1:0] quo_out
);

  localparam int unsigned   CW    = $clog2(num_w_p + 1);
  localparam logic [CW-1:0] STEPS = CW'(num_w_p);
  localparam logic [CW-1:0] LAST  = CW'(1);

  logic               busy_q, busy_d, done_q, done_d, ge;
  logic [CW-1:0]      step_q, step_d;
  logic [den_w_p-1:0] rem_q, rem_d, den_q, den_d;
  logic [den_w_p:0]   rem_sh;
  logic [num_w_p-1:0] num_q, num_d, quo_q, quo_d;

  // Remainder stays below the divisor, so the shifted value needs one extra bit.
  always_comb begin
    rem_sh = {rem_q, num_q[num_w_p-1]};
    ge     = rem_sh >= {1'b0, den_q};
    busy_d = busy_q;
    done_d = 1'b0;
    step_d = step_q;
    rem_d  = rem_q;
    den_d  = den_q;
    num_d  = num_q;
    quo_d  = quo_q;
    if (!busy_q) begin
      if (start_in) begin
        busy_d = 1'b1;
        step_d = STEPS;
        rem_d  = '0;
        den_d  = den_in;
        num_d  = num_in;
      end
    end else begin
      rem_d  = ge ? (rem_sh[den_w_p-1:0] - den_q) : rem_sh[den_w_p-1:0];
      num_d  = {num_q[num_w_p-2:0], ge};
      step_d = step_q - LAST;
      if (step_q == LAST) begin
        busy_d = 1'b0;
        done_d = 1'b1;
        quo_d  = {num_q[num_w_p-2:0], ge};
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      step_q <= '0;
      rem_q  <= '0;
      den_q  <= '0;
      num_q  <= '0;
      quo_q  <= '0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      step_q <= step_d;
      rem_q  <= rem_d;
      den_q  <= den_d;
      num_q  <= num_d;
      quo_q  <= quo_d;
    end
  end

  assign busy_out = busy_q;
  assign done_out = done_q;
  assign quo_out  = quo_q;

endmodule

// File: rtl/pwm_meter.sv
// rtl/pwm_meter.sv - PWM period/high-time meter with loss-of-signal flag; duty output under PWM_METER_DUTY_EN
module pwm_meter
  import pwm_meter_pkg::*;
#(
  parameter int unsigned            cnt_width_p = 24,
  parameter logic [cnt_width_p-1:0] timeout_p   = cnt_width_p'(16_777_000)
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic                   pwm_in,
  output logic [cnt_width_p-1:0] period_cnt_out,
  output logic [cnt_width_p-1:0] high_cnt_out,
  output logic                   meas_valid_out,
  output logic                   timeout_out
`ifdef PWM_METER_DUTY_EN
  ,
  output logic [DUTY_W-1:0]      duty_out,
  output logic                   duty_valid_out
`endif
);

  typedef logic [cnt_width_p-1:0] cnt_t;
  localparam cnt_t CNT_ONE = {{(cnt_width_p-1){1'b0}}, 1'b1};
  localparam cnt_t CNT_MAX = '1;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   pwm_dly_q, pwm_dly_d, pwm_s, rise;
  logic [0:0]             state_q, state_d;
  cnt_t                   per_cnt_q, per_cnt_d, hi_cnt_q, hi_cnt_d;
  cnt_t                   period_q, period_d, high_q, high_d;
  logic                   valid_q, valid_d, timeout_q, timeout_d;

  assign pwm_s     = sync_q[SYNC_STAGES-1];
  assign rise      = pwm_s & ~pwm_dly_q;
  assign pwm_dly_d = pwm_s;

  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], pwm_in};
    state_d   = state_q;
    per_cnt_d = per_cnt_q;
    hi_cnt_d  = hi_cnt_q;
    period_d  = period_q;
    high_d    = high_q;
    valid_d   = 1'b0;
    timeout_d = timeout_q;
    if (rise) begin
      per_cnt_d = CNT_ONE;
      hi_cnt_d  = CNT_ONE;
      timeout_d = 1'b0;
    end else begin
      if (per_cnt_q != CNT_MAX) per_cnt_d = per_cnt_q + CNT_ONE;
      if (pwm_s && hi_cnt_q != CNT_MAX) hi_cnt_d = hi_cnt_q + CNT_ONE;
    end
    // The first edge after IDLE only opens a period; a rise always beats the timeout.
    case (state_q)
      ST_IDLE: begin
        if (rise) state_d = ST_MEASURE;
      end
      ST_MEASURE: begin
        if (rise) begin
          period_d = per_cnt_q;
          high_d   = hi_cnt_q;
          valid_d  = 1'b1;
        end else if (per_cnt_q == timeout_p) begin
          timeout_d = 1'b1;
          period_d  = '0;
          high_d    = '0;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sync_q    <= '0;
      pwm_dly_q <= 1'b0;
      state_q   <= ST_IDLE;
      per_cnt_q <= '0;
      hi_cnt_q  <= '0;
      period_q  <= '0;
      high_q    <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      pwm_dly_q <= pwm_dly_d;
      state_q   <= state_d;
      per_cnt_q <= per_cnt_d;
      hi_cnt_q  <= hi_cnt_d;
      period_q  <= period_d;
      high_q    <= high_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  assign period_cnt_out = period_q;
  assign high_cnt_out   = high_q;
  assign meas_valid_out = valid_q;
  assign timeout_out    = timeout_q;

`ifdef PWM_METER_DUTY_EN
  localparam int unsigned NUM_W = cnt_width_p + DUTY_W;

  logic [NUM_W-1:0] div_quo;
  logic             div_busy, div_done;

  pwm_meter_div #(
    .num_w_p(NUM_W),
    .den_w_p(cnt_width_p)
  ) u_div (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .start_in (valid_q & ~div_busy),
    .num_in   ({high_q, {DUTY_W{1'b0}}}),
    .den_in   (period_q),
    .busy_out (div_busy),
    .done_out (div_done),
    .quo_out  (div_quo)
  );

  // Quotient can reach 256 only when high equals period.
  assign duty_out       = (|div_quo[NUM_W-1:DUTY_W]) ? '1 : div_quo[DUTY_W-1:0];
  assign duty_valid_out = div_done;
`endif

endmodule
